// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, engine state encoding, A10 position.
package sdram_pkg;

   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_NOP = 4'b0111;

   localparam int unsigned A10_BIT = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_ACT,
      ST_READ,
      ST_PRE
   } sdram_state_e;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sdram_rd_dpipe.sv
// Read-data capture: valid delayed DEPTH cycles, DQ registered once.
module sdram_rd_dpipe #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DQ_W  = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            vld_i,
   input  logic [DQ_W-1:0] data_i,
   output logic            vld_o,
   output logic [DQ_W-1:0] data_o
);

   logic [DEPTH-1:0] vld_q, vld_d;
   logic [DQ_W-1:0]  data_q, data_d;

   always_comb begin
      vld_d  = {vld_q[DEPTH-2:0], vld_i};
      data_d = data_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= '0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

   assign vld_o  = vld_q[DEPTH-1];
   assign data_o = data_q;

endmodule

// File: rtl/sdram_rd_burst.sv
// Multi-burst SDRAM read engine: arbiter handshake, row crossing, refresh yield/resume.
module sdram_rd_burst
   import sdram_pkg::*;
#(
   parameter int unsigned DQ_W      = 16,
   parameter int unsigned BANK_W    = 2,
   parameter int unsigned ROW_W     = 12,
   parameter int unsigned COL_W     = 9,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned CAS_LAT   = 3,
   parameter int unsigned TRCD      = 3,
   parameter int unsigned TRP       = 3,
   parameter int unsigned LEN_W     = 16
) (
   input  logic                            s_clk,
   input  logic                            s_rst,
   input  logic                            rd_trig,
   input  logic [BANK_W+ROW_W+COL_W-1:0]   rd_start_addr,
   input  logic [LEN_W-1:0]                rd_len,
   input  logic                            aref_req,
   input  logic                            rd_en,
   input  logic [DQ_W-1:0]                 sdram_data,
   output logic                            rd_req,
   output logic                            rd_end,
   output logic                            rd_done,
   output logic                            busy,
   output logic [3:0]                      rd_cmd,
   output logic [ROW_W-1:0]                rd_addr,
   output logic [BANK_W-1:0]               rd_bank,
   output logic [DQ_W-1:0]                 rfifo_wr_data,
   output logic                            rfifo_wr_en
);

   localparam int unsigned AW    = BANK_W + ROW_W + COL_W;
   localparam int unsigned CNT_W = $clog2(max3(TRCD, TRP, BURST_LEN));

   if (!(BURST_LEN == 1 || BURST_LEN == 2 || BURST_LEN == 4 || BURST_LEN == 8)) begin : g_bad_bl
      $error("BURST_LEN must be 1, 2, 4 or 8");
   end
   if (!(CAS_LAT == 2 || CAS_LAT == 3)) begin : g_bad_cl
      $error("CAS_LAT must be 2 or 3");
   end
   if (ROW_W < 11) begin : g_bad_row
      $error("ROW_W must be at least 11");
   end
   if (COL_W > 10) begin : g_bad_col
      $error("COL_W must be at most 10");
   end
   if (TRCD < 2 || TRP < 2) begin : g_bad_t
      $error("TRCD and TRP must be at least 2");
   end

   sdram_state_e       state_q, state_d, tgt_q, tgt_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic [3:0]         rd_cmd_q, rd_cmd_d;
   logic [ROW_W-1:0]   rd_addr_q, rd_addr_d;
   logic [BANK_W-1:0]  rd_bank_q, rd_bank_d;
   logic               rd_req_q, rd_req_d;
   logic               rd_end_q, rd_end_d;
   logic               rd_done_q, rd_done_d;
   logic               busy_q, busy_d;
   logic               do_rd;

   logic [COL_W-1:0]   cur_col;
   logic [ROW_W-1:0]   cur_row;
   logic [BANK_W-1:0]  cur_bank;

   assign cur_col  = addr_q[COL_W-1:0];
   assign cur_row  = addr_q[COL_W +: ROW_W];
   assign cur_bank = addr_q[AW-1 -: BANK_W];

   always_comb begin
      state_d   = state_q;
      tgt_d     = tgt_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      rd_cmd_d  = CMD_NOP;
      rd_addr_d = '0;
      rd_bank_d = '0;
      rd_req_d  = 1'b0;
      rd_end_d  = 1'b0;
      rd_done_d = 1'b0;
      do_rd     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rd_trig && rd_len != '0) begin
               state_d  = ST_REQ;
               addr_d   = rd_start_addr & ~AW'(BURST_LEN - 1);
               rem_d    = rd_len;
               rd_req_d = 1'b1;
            end
         end
         ST_REQ: begin
            if (rd_en) begin
               state_d   = ST_ACT;
               cnt_d     = '0;
               rd_cmd_d  = CMD_ACT;
               rd_addr_d = cur_row;
               rd_bank_d = cur_bank;
            end else begin
               rd_req_d = 1'b1;
            end
         end
         ST_ACT: begin
            if (cnt_q == CNT_W'(TRCD - 1)) do_rd = 1'b1;
            else                           cnt_d = cnt_q + CNT_W'(1);
         end
         ST_READ: begin
            // addr_q has already advanced past the burst in flight, so col 0 means row end
            if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
               if (rem_q == '0 || cur_col == '0 || aref_req) begin
                  state_d   = ST_PRE;
                  cnt_d     = '0;
                  rd_cmd_d  = CMD_PRE;
                  rd_addr_d = ROW_W'(1) << A10_BIT;
                  tgt_d     = (rem_q == '0) ? ST_IDLE : (aref_req ? ST_REQ : ST_ACT);
               end else begin
                  do_rd = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_PRE: begin
            if (cnt_q == CNT_W'(TRP - 2) && tgt_q != ST_ACT) begin
               rd_end_d  = 1'b1;
               rd_done_d = (tgt_q == ST_IDLE);
            end
            if (cnt_q == CNT_W'(TRP - 1)) begin
               state_d  = tgt_q;
               cnt_d    = '0;
               rd_req_d = (tgt_q == ST_REQ);
               if (tgt_q == ST_ACT) begin
                  rd_cmd_d  = CMD_ACT;
                  rd_addr_d = cur_row;
                  rd_bank_d = cur_bank;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (do_rd) begin
         state_d   = ST_READ;
         cnt_d     = '0;
         rd_cmd_d  = CMD_RD;
         rd_addr_d = ROW_W'(cur_col);
         rd_bank_d = cur_bank;
         rem_d     = rem_q - LEN_W'(1);
         addr_d    = addr_q + AW'(BURST_LEN);
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         state_q   <= ST_IDLE;
         tgt_q     <= ST_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         rem_q     <= '0;
         rd_cmd_q  <= CMD_NOP;
         rd_addr_q <= '0;
         rd_bank_q <= '0;
         rd_req_q  <= 1'b0;
         rd_end_q  <= 1'b0;
         rd_done_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tgt_q     <= tgt_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         rd_cmd_q  <= rd_cmd_d;
         rd_addr_q <= rd_addr_d;
         rd_bank_q <= rd_bank_d;
         rd_req_q  <= rd_req_d;
         rd_end_q  <= rd_end_d;
         rd_done_q <= rd_done_d;
         busy_q    <= busy_d;
      end
   end

   assign rd_cmd  = rd_cmd_q;
   assign rd_addr = rd_addr_q;
   assign rd_bank = rd_bank_q;
   assign rd_req  = rd_req_q;
   assign rd_end  = rd_end_q;
   assign rd_done = rd_done_q;
   assign busy    = busy_q;

   // every READ-state cycle corresponds to one returned beat CAS_LAT+1 cycles later
   sdram_rd_dpipe #(
      .DEPTH (CAS_LAT + 1),
      .DQ_W  (DQ_W)
   ) u_dpipe (
      .clk    (s_clk),
      .rst    (s_rst),
      .vld_i  (state_q == ST_READ),
      .data_i (sdram_data),
      .vld_o  (rfifo_wr_en),
      .data_o (rfifo_wr_data)
   );

endmodule

// File: tb/tb_sdram_rd_burst.sv
// Bench for sdram_rd_burst: event-schedule reference model plus directed and random transfers.
module tb_sdram_rd_burst;

   localparam int DQ_W = 16, BANK_W = 2, ROW_W = 12, COL_W = 9;
   localparam int BL = 4, CAS = 3, TRCD = 3, TRP = 3, LEN_W = 16;
   localparam int AW  = BANK_W + ROW_W + COL_W;
   localparam int INF = 32'h7fff_ffff;
   localparam logic [3:0] C_ACT = 4'b0011, C_RD = 4'b0101, C_PRE = 4'b0010, C_NOP = 4'b0111;

   logic              clk;
   logic              s_rst, rd_trig, aref_req, rd_en;
   logic [AW-1:0]     rd_start_addr;
   logic [LEN_W-1:0]  rd_len;
   logic [DQ_W-1:0]   sdram_data;
   logic              rd_req, rd_end, rd_done, busy, rfifo_wr_en;
   logic [3:0]        rd_cmd;
   logic [ROW_W-1:0]  rd_addr;
   logic [BANK_W-1:0] rd_bank;
   logic [DQ_W-1:0]   rfifo_wr_data;

   sdram_rd_burst #(
      .DQ_W(DQ_W), .BANK_W(BANK_W), .ROW_W(ROW_W), .COL_W(COL_W), .BURST_LEN(BL),
      .CAS_LAT(CAS), .TRCD(TRCD), .TRP(TRP), .LEN_W(LEN_W)
   ) dut (
      .s_clk(clk), .s_rst(s_rst), .rd_trig(rd_trig), .rd_start_addr(rd_start_addr),
      .rd_len(rd_len), .aref_req(aref_req), .rd_en(rd_en), .sdram_data(sdram_data),
      .rd_req(rd_req), .rd_end(rd_end), .rd_done(rd_done), .busy(busy), .rd_cmd(rd_cmd),
      .rd_addr(rd_addr), .rd_bank(rd_bank), .rfifo_wr_data(rfifo_wr_data),
      .rfifo_wr_en(rfifo_wr_en)
   );

   int cyc = 0;
   int n_vec = 0, n_err = 0;
   int strobes = 0, n_end = 0, n_done = 0, last_done = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Reference model: schedules the expected output timeline from the protocol's timing rules
   logic [3:0]        exp_cmd[int];
   logic [ROW_W-1:0]  exp_a[int];
   logic [BANK_W-1:0] exp_b[int];
   bit                exp_en[int], exp_end[int], exp_done[int];
   logic [DQ_W-1:0]   dq_hist[int];
   logic [AW-1:0]     m_next;
   int                m_rem, m_req_from, m_bnd = -1, m_idle_at = 0;
   int                busy_from = INF, busy_to = INF;
   bit                m_busy = 1'b0, m_wait = 1'b0;

   task automatic sched_rd(input int r);
      exp_cmd[r] = C_RD;
      exp_a[r]   = ROW_W'(m_next[COL_W-1:0]);
      exp_b[r]   = m_next[AW-1 -: BANK_W];
      for (int k = 1; k <= BL; k++) exp_en[r + CAS + k] = 1'b1;
      m_rem  = m_rem - 1;
      m_next = m_next + AW'(BL);
      m_bnd  = r + BL - 1;
   endtask

   task automatic sched_act(input int a);
      exp_cmd[a] = C_ACT;
      exp_a[a]   = m_next[COL_W +: ROW_W];
      exp_b[a]   = m_next[AW-1 -: BANK_W];
      sched_rd(a + TRCD);
   endtask

   task automatic boundary(input int c);
      int p;
      m_bnd = -1;
      if (m_rem == 0 || m_next[COL_W-1:0] == '0 || aref_req) begin
         p = c + 1;
         exp_cmd[p] = C_PRE;
         exp_a[p]   = 12'h400;
         exp_b[p]   = '0;
         if (m_rem == 0) begin
            exp_end[p + TRP - 1]  = 1'b1;
            exp_done[p + TRP - 1] = 1'b1;
            m_busy    = 1'b0;
            m_idle_at = p + TRP;
            busy_to   = p + TRP;
         end else if (aref_req) begin
            exp_end[p + TRP - 1] = 1'b1;
            m_wait     = 1'b1;
            m_req_from = p + TRP;
         end else begin
            sched_act(p + TRP);
         end
      end else begin
         sched_rd(c + 1);
      end
   endtask

   always @(negedge clk) begin : mon
      logic [3:0] e_cmd;
      bit         e_en;
      dq_hist[cyc] = sdram_data;
      if (s_rst) begin
         chk("rst_cmd", 32'(rd_cmd), 32'(C_NOP));
         chk("rst_addr", 32'(rd_addr), 0);
         chk("rst_bank", 32'(rd_bank), 0);
         chk("rst_req", 32'(rd_req), 0);
         chk("rst_end", 32'(rd_end), 0);
         chk("rst_done", 32'(rd_done), 0);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_wr_en", 32'(rfifo_wr_en), 0);
         chk("rst_wr_data", 32'(rfifo_wr_data), 0);
         exp_cmd.delete(); exp_a.delete(); exp_b.delete();
         exp_en.delete(); exp_end.delete(); exp_done.delete();
         m_busy = 1'b0; m_wait = 1'b0; m_bnd = -1; m_idle_at = 0;
         busy_from = INF; busy_to = INF;
      end else begin
         e_cmd = exp_cmd.exists(cyc) ? exp_cmd[cyc] : C_NOP;
         e_en  = exp_en.exists(cyc);
         chk("cmd", 32'(rd_cmd), 32'(e_cmd));
         chk("addr", 32'(rd_addr), exp_a.exists(cyc) ? 32'(exp_a[cyc]) : 0);
         chk("bank", 32'(rd_bank), exp_b.exists(cyc) ? 32'(exp_b[cyc]) : 0);
         chk("rd_req", 32'(rd_req), 32'(m_wait && cyc >= m_req_from));
         chk("busy", 32'(busy), 32'(cyc >= busy_from && cyc < busy_to));
         chk("rd_end", 32'(rd_end), 32'(exp_end.exists(cyc)));
         chk("rd_done", 32'(rd_done), 32'(exp_done.exists(cyc)));
         chk("wr_en", 32'(rfifo_wr_en), 32'(e_en));
         if (e_en) chk("wr_data", 32'(rfifo_wr_data), 32'(dq_hist[cyc - 1]));

         if (!m_busy && cyc >= m_idle_at && rd_trig && rd_len != '0) begin
            m_busy     = 1'b1;
            m_wait     = 1'b1;
            m_next     = rd_start_addr & ~AW'(BL - 1);
            m_rem      = int'(rd_len);
            m_req_from = cyc + 1;
            busy_from  = cyc + 1;
            busy_to    = INF;
         end else if (m_wait && cyc >= m_req_from && rd_en) begin
            m_wait = 1'b0;
            sched_act(cyc + 1);
         end
         if (m_bnd == cyc) boundary(cyc);
      end
      if (rfifo_wr_en) strobes++;
      if (rd_end) n_end++;
      if (rd_done) begin
         n_done++;
         last_done = cyc;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1 sdram_data = DQ_W'($urandom);
      end
   end

   // One transfer: gdly<0 ties rd_en high; aref_at/trig2_at/rst_at are cycle offsets after the trigger
   task automatic xfer(input logic [AW-1:0] a, input int len, input int gdly, input int aref_at,
                       input int trig2_at, input int rst_at, input bit rnd, output int t0);
      int  n, reqc;
      bit  fin;
      @(posedge clk); #1;
      rd_trig = 1'b1; rd_start_addr = a; rd_len = LEN_W'(len); t0 = cyc;
      if (gdly < 0) rd_en = 1'b1;
      n = 0; reqc = 0; fin = 1'b0;
      while (!fin) begin
         @(posedge clk); #1;
         n++;
         rd_trig = 1'b0;
         if (rst_at > 0 && n == rst_at + 2) s_rst = 1'b0;
         if (n > 2 && !busy && !s_rst) begin
            fin = 1'b1;
         end else if (n > 3000) begin
            chk("xfer_timeout", 1, 0);
            fin = 1'b1;
         end else begin
            if (gdly >= 0) begin
               reqc  = rd_req ? reqc + 1 : 0;
               rd_en = rd_req ? (reqc > gdly) : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
            end
            if (rd_end) aref_req = 1'b0;
            else if (n == aref_at || (rnd && $urandom_range(0, 14) == 0)) aref_req = 1'b1;
            if (n == trig2_at || (rnd && $urandom_range(0, 9) == 0)) begin
               rd_trig = 1'b1;
               rd_start_addr = AW'($urandom);
               rd_len = LEN_W'($urandom_range(0, 3));
            end
            if (n == rst_at) begin
               #3 s_rst = 1'b1;
            end
         end
      end
      rd_trig = 1'b0; rd_en = 1'b0; aref_req = 1'b0;
      repeat (12) @(posedge clk);
   endtask

   initial begin
      int t0, s0, e0, d0;
      logic [AW-1:0] a;
      s_rst = 1'b1; rd_trig = 1'b0; aref_req = 1'b0; rd_en = 1'b0;
      rd_start_addr = '0; rd_len = '0; sdram_data = '0;
      repeat (3) @(posedge clk);
      #1 s_rst = 1'b0;
      repeat (2) @(posedge clk);

      s0 = strobes; e0 = n_end; d0 = n_done;
      xfer('0, 2, -1, -1, -1, -1, 1'b0, t0);
      chk("basic_done_cyc", 32'(last_done - t0), 15);
      chk("basic_strobes", 32'(strobes - s0), 8);
      chk("basic_end_cnt", 32'(n_end - e0), 1);

      s0 = strobes; e0 = n_end; d0 = n_done;
      xfer({2'd0, 12'd5, 9'd508}, 2, -1, -1, -1, -1, 1'b0, t0);
      chk("xrow_done_cyc", 32'(last_done - t0), 21);
      chk("xrow_end_cnt", 32'(n_end - e0), 1);
      chk("xrow_done_cnt", 32'(n_done - d0), 1);

      s0 = strobes; e0 = n_end; d0 = n_done;
      xfer({2'd1, 12'd3, 9'd0}, 4, -1, 10, -1, -1, 1'b0, t0);
      chk("aref_strobes", 32'(strobes - s0), 16);
      chk("aref_end_cnt", 32'(n_end - e0), 2);
      chk("aref_done_cyc", 32'(last_done - t0), 30);

      d0 = n_done;
      xfer({2'd2, 12'd100, 9'd64}, 3, 10, -1, 5, -1, 1'b0, t0);
      chk("gnt_done_cyc", 32'(last_done - t0), 29);
      chk("gnt_done_cnt", 32'(n_done - d0), 1);

      @(posedge clk); #1;
      rd_trig = 1'b1; rd_len = '0; rd_start_addr = AW'(12345);
      @(posedge clk); #1;
      rd_trig = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("len0_busy", 32'(busy), 0);
      chk("len0_req", 32'(rd_req), 0);

      a = '1;
      xfer(a - AW'(3), 2, -1, -1, -1, -1, 1'b0, t0);
      chk("wrap_done_cyc", 32'(last_done - t0), 21);

      s0 = strobes; d0 = n_done;
      xfer({2'd3, 12'd7, 9'd0}, 3, -1, -1, -1, 10, 1'b0, t0);
      chk("rst_strobes", 32'(strobes - s0), 1);
      chk("rst_no_done", 32'(n_done - d0), 0);

      for (int i = 0; i < 30; i++) begin
         a = AW'($urandom);
         if ($urandom_range(0, 1) == 1) a[COL_W-1:0] = COL_W'(512 - BL * $urandom_range(1, 3));
         d0 = n_done;
         xfer(a, $urandom_range(1, 6), $urandom_range(0, 4), -1, -1, -1, 1'b1, t0);
         chk("rnd_done_cnt", 32'(n_done - d0), 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sdram_rd_burst.md
# sdram_rd_burst

Parametrised SDRAM read engine. It is the successor to the fixed single-bank, byte-output read controller. On a trigger it reads a programmable number of bursts from any linear start address and pushes every captured word into the read FIFO. It sits between the SDRAM arbiter (request/grant plus refresh handshake) and the read FIFO. Data width, geometry, burst length, CAS latency and tRCD/tRP are parameters. It crosses rows automatically, yields to auto-refresh at burst boundaries, and resumes where it stopped.

## Interface
- DQ_W, 16, SDRAM data width, also the FIFO word width
- BANK_W, 2, bank address bits
- ROW_W, 12, row bits (≥11; A10 is used for precharge-all)
- COL_W, 9, column bits (≤10)
- BURST_LEN, 4, burst length: 1, 2, 4 or 8
- CAS_LAT, 3, CAS latency: 2 or 3
- TRCD, 3, ACT-to-RD cycles (≥2)
- TRP, 3, PRE-to-next-command cycles (≥2)
- LEN_W, 16, width of the burst-count input
- s_clk  in  1  system clock; single clock domain
- s_rst  in  1  asynchronous, active-high reset
- rd_trig  in  1  start pulse; sampled only in IDLE
- rd_start_addr  in  BANK_W+ROW_W+COL_W  linear word address {bank,row,col}; the low log2(BURST_LEN) bits are forced to 0
- rd_len  in  LEN_W  number of bursts; 0 causes rd_trig to be ignored
- aref_req  in  1  refresh pending, from the arbiter
- rd_en  in  1  bus grant, from the arbiter
- sdram_data  in  DQ_W  SDRAM DQ
- rd_req  out  1  bus request
- rd_end  out  1  one-cycle pulse: bus released (refresh yield or completion)
- rd_done  out  1  one-cycle pulse: whole transfer finished
- busy  out  1  high whenever the state is not IDLE
- rd_cmd  out  4  {CS_n,RAS_n,CAS_n,WE_n}
- rd_addr  out  ROW_W  SDRAM address bus
- rd_bank  out  BANK_W  bank address
- rfifo_wr_data  out  DQ_W  captured read word
- rfifo_wr_en  out  1  FIFO write strobe

## Operation
- The FSM has five states: IDLE, REQ, ACT, READ, PRE.
- Transitions:
  - IDLE→REQ on rd_trig with rd_len≠0. The address and length are latched at this point.
  - REQ→ACT when rd_en=1.
  - ACT→READ after TRCD cycles.
  - READ→PRE at a burst boundary, when any of these holds: the last burst has been issued, the column has wrapped (row end), or aref_req=1.
  - PRE→IDLE after TRP cycles if the transfer is complete. rd_end and rd_done pulse together.
  - PRE→REQ after TRP cycles if aref_req=1. rd_end pulses and rd_req re-asserts next cycle.
  - PRE→ACT after TRP cycles otherwise (new row).
- Commands are ACT=0011, RD=0101, PRE=0010, NOP=0111. Every cycle without a command drives NOP.
- ACT: rd_addr=row, rd_bank=bank.
- RD: rd_addr = column zero-extended, with A10=0 (no auto-precharge). rd_bank=bank.
- PRE: rd_addr = A10 set, all other bits 0. rd_bank=0.
- NOP cycles drive rd_addr=0 and rd_bank=0.
- After each RD the current address advances by BURST_LEN.
- Column wrap carries into the row; row wrap carries into the bank. The top address wraps to 0.
- The remaining-burst count decrements on each RD.
- aref_req is examined only at burst boundaries in READ. A refresh arriving mid-burst waits for the burst to finish.
- Data capture is a valid/data delay line: rfifo_wr_en is high for BURST_LEN consecutive cycles per RD.
- rfifo_wr_data is sdram_data registered once. The full DQ_W width is kept; there is no truncation.
- rd_trig in any non-IDLE state is ignored. rd_en outside REQ is ignored.

## Timing
- Reset values: rd_cmd=NOP, rd_addr=0, rd_bank=0, rd_req=0, rd_end=0, rd_done=0, busy=0, rfifo_wr_en=0, rfifo_wr_data=0. The state is IDLE and the delay line is cleared.
- rd_trig sampled high at cycle 0 → rd_req=1 from cycle 1.
- rd_en sampled high at cycle k → ACT on rd_cmd at cycle k+1. rd_req drops at k+1.
- The first RD appears TRCD cycles after ACT. Subsequent RDs follow every BURST_LEN cycles, back-to-back, with no gap inside a row.
- PRE appears BURST_LEN cycles after the last RD of a row or segment.
- The next command after PRE comes TRP cycles later. rd_end/rd_done fall in the last PRE cycle (PRE+TRP-1).
- For an RD at cycle t, rfifo_wr_en is high over t+CAS_LAT+1 … t+CAS_LAT+BURST_LEN.
- Data strobes of the last burst may extend past PRE or rd_done. The delay line drains independently of the FSM.
- Asynchronous reset mid-transfer aborts immediately. All outputs return to reset values, including the in-flight strobes.

## Structure
- The shared package sdram_pkg holds the command constants (ACT, RD, PRE, NOP), the state encoding, and the A10 precharge-all constant. The write engine shares this package.
- Sub-module sdram_rd_dpipe implements the CAS_LAT+1 delay line for valid and data, with asynchronous reset.
- Elaboration-time checks cover the legal BURST_LEN, CAS_LAT, ROW_W and COL_W values.

## Test plan
All scenarios use default parameters.
- Basic transfer: start 0, rd_len=2, rd_en tied high.
  - ACT row0/bank0 at cycle 2, RD col0 at 5, RD col4 at 9, PRE addr 0x400 at 13.
  - rd_done at 15.
  - rfifo_wr_en over cycles 9–12 and 13–16.
- Row crossing: start {b0,r5,col 508}, rd_len=2.
  - RD col508, then PRE, ACT row6, RD col0.
  - rd_end/rd_done pulse once, at the end only.
- Refresh yield: aref_req raised mid-burst 2 of 4.
  - Burst 2 completes, then PRE and rd_end.
  - rd_req re-asserts; after grant, ACT on the same row and RD resumes at burst 3's column.
  - Total strobes = 16.
- Grant delay and triggers: rd_en held low 10 cycles.
  - rd_req stays high and rd_cmd stays NOP until the grant.
  - A second rd_trig while busy is ignored; rd_len=0 causes no activity.
- Address wrap: start at top address minus 3, rd_len=2.
  - The second RD goes to bank0/row0/col0.
- Reset mid-READ: assert s_rst between two RDs.
  - All outputs return to reset values in the same cycle.
  - No further rfifo_wr_en after reset.
